// File: rtl/regfile_write_port_if.sv
// Write-request channel into the integer register file write port.
// The pipeline side drives the request; the write port answers with ready.
interface regfile_write_port_if #(
  parameter int WIDTH = 64
);
  logic             wr_valid;
  logic             wr_ready;
  logic [4:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/regfile_write_port.sv
// Write side of the 32-entry integer register file: a small FIFO of pending
// write-backs draining one entry per cycle into the array. Register 31 is XZR.
module regfile_write_port #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_write_port_if.slave   wr,
  input  logic                  drain_stall_i,
  output logic [31:0]           commit_en_o,
  output logic [31:0]           pending_o,
  output logic [32*WIDTH-1:0]   regs_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [4:0]       addr_q [DEPTH];
  logic [4:0]       addr_d [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  ptr_t             head_q, head_d;
  ptr_t             tail_q, tail_d;
  cnt_t             count_q, count_d;
  logic [WIDTH-1:0] reg_q [31];
  logic [WIDTH-1:0] reg_d [31];

  logic             accept;
  logic             commit;
  logic [DEPTH-1:0] valid;
  logic [4:0]       head_addr;
  logic [31:0]      pend_raw;

  assign wr.wr_ready = (count_q < cnt_t'(DEPTH));
  assign accept      = wr.wr_valid && wr.wr_ready;
  assign commit      = (count_q != '0) && !drain_stall_i;
  assign head_addr   = addr_q[head_q];

  // An entry is live when its distance from head is below count.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = {1'b0, ptr_t'(ptr_t'(i) - head_q)} < count_q;
    end
  end

  always_comb begin
    pend_raw = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) pend_raw = pend_raw | (32'd1 << addr_q[i]);
    end
    pending_o = pend_raw & 32'h7FFF_FFFF;
  end

  always_comb begin
    commit_en_o = '0;
    if (commit && head_addr != 5'd31) commit_en_o = 32'd1 << head_addr;
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    head_d = head_q;
    tail_d = tail_q;
    reg_d  = reg_q;
    if (accept) begin
      addr_d[tail_q] = wr.wr_addr;
      data_d[tail_q] = wr.wr_data;
      tail_d         = tail_q + ptr_t'(1);
    end
    if (commit) head_d = head_q + ptr_t'(1);
    for (int i = 0; i < 31; i++) begin
      if (commit_en_o[i]) reg_d[i] = data_q[head_q];
    end
    case ({accept, commit})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      for (int i = 0; i < 31; i++) reg_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      reg_q   <= reg_d;
    end
  end

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < 31; i++) regs_o[i*WIDTH +: WIDTH] = reg_q[i];
  end

endmodule

// File: tb/tb_regfile_write_port.sv
// Randomized bench for regfile_write_port against a queue/array reference model.
module tb_regfile_write_port;
  localparam int W     = 64;
  localparam int DEPTH = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              drain_stall;
  logic [31:0]       commit_en;
  logic [31:0]       pending;
  logic [32*W-1:0]   regs;

  regfile_write_port_if #(.WIDTH(W)) wif ();

  regfile_write_port #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr            (wif),
    .drain_stall_i (drain_stall),
    .commit_en_o   (commit_en),
    .pending_o     (pending),
    .regs_o        (regs)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] a; logic [W-1:0] d; } ent_t;
  ent_t         mq[$];
  logic [W-1:0] mregs [32];
  int           n_checks = 0;
  int           n_pass   = 0;

  function automatic logic exp_ready();
    return mq.size() < DEPTH;
  endfunction

  function automatic logic [31:0] exp_commit();
    if (mq.size() > 0 && !drain_stall && mq[0].a != 5'd31) return 32'd1 << mq[0].a;
    return 32'd0;
  endfunction

  function automatic logic [31:0] exp_pending();
    logic [31:0] p = '0;
    foreach (mq[i]) if (mq[i].a != 5'd31) p[mq[i].a] = 1'b1;
    return p;
  endfunction

  function automatic int first_bad_reg();
    for (int r = 0; r < 32; r++) if (regs[r*W +: W] !== mregs[r]) return r;
    return -1;
  endfunction

  task automatic drive(input logic v, input logic [4:0] a, input logic [W-1:0] d,
                       input logic s, input logic rst = 1'b0);
    @(negedge clk);
    wif.wr_valid = v; wif.wr_addr = a; wif.wr_data = d;
    drain_stall = s; reset = rst;
    #1;
  endtask

  task automatic tick();
    logic acc, com;
    ent_t e;
    @(posedge clk);
    acc = wif.wr_valid && (mq.size() < DEPTH);
    com = (mq.size() > 0) && !drain_stall;
    if (reset) begin
      mq.delete();
      for (int r = 0; r < 32; r++) mregs[r] = '0;
    end else begin
      if (com) begin
        e = mq.pop_front();
        if (e.a != 5'd31) mregs[e.a] = e.d;
      end
      if (acc) begin
        e.a = wif.wr_addr; e.d = wif.wr_data;
        mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    int bad;
    drive(1'b0, 5'd0, '0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 5'd0, '0, 1'b0);
    n_checks++; if (wif.wr_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", wif.wr_ready); else n_pass++;
    n_checks++; if (commit_en !== 32'd0) $display("FAIL reset_commit got %h want 0", commit_en); else n_pass++;
    n_checks++; if (pending !== 32'd0) $display("FAIL reset_pending got %h want 0", pending); else n_pass++;
    bad = -1;
    for (int r = 0; r < 32; r++) if (bad < 0 && regs[r*W +: W] !== '0) bad = r;
    n_checks++; if (bad >= 0) $display("FAIL reset_regs reg %0d got %h want 0", bad, regs[bad*W +: W]); else n_pass++;
  endtask

  task automatic test_single();
    drive(1'b1, 5'd5, 64'hDEAD, 1'b0);
    n_checks++; if (commit_en !== 32'd0) $display("FAIL single_idle_commit got %h want 0", commit_en); else n_pass++;
    tick();
    drive(1'b0, 5'd0, '0, 1'b0);
    n_checks++; if (commit_en !== 32'h20) $display("FAIL single_commit got %h want 00000020", commit_en); else n_pass++;
    n_checks++; if (regs[5*W +: W] !== '0) $display("FAIL single_early got %h want 0", regs[5*W +: W]); else n_pass++;
    tick();
    n_checks++; if (regs[5*W +: W] !== 64'hDEAD) $display("FAIL single_reg5 got %h want dead", regs[5*W +: W]); else n_pass++;
  endtask

  task automatic test_stall();
    drive(1'b1, 5'd3, 64'hA3, 1'b1); tick();
    drive(1'b1, 5'd7, 64'hB7, 1'b1); tick();
    drive(1'b1, 5'd11, 64'hCB, 1'b1);
    n_checks++; if (pending !== 32'h88) $display("FAIL stall_pending got %h want 00000088", pending); else n_pass++;
    n_checks++; if (wif.wr_ready !== 1'b0) $display("FAIL stall_ready got %b want 0", wif.wr_ready); else n_pass++;
    n_checks++; if (commit_en !== 32'd0) $display("FAIL stall_commit got %h want 0", commit_en); else n_pass++;
    tick();
    drive(1'b1, 5'd11, 64'hCB, 1'b0);
    n_checks++; if (commit_en !== 32'h8) $display("FAIL release_c3 got %h want 00000008", commit_en); else n_pass++;
    n_checks++; if (wif.wr_ready !== 1'b0) $display("FAIL full_no_pass got %b want 0", wif.wr_ready); else n_pass++;
    tick();
    drive(1'b1, 5'd11, 64'hCB, 1'b0);
    n_checks++; if (commit_en !== 32'h80) $display("FAIL release_c7 got %h want 00000080", commit_en); else n_pass++;
    n_checks++; if (regs[3*W +: W] !== 64'hA3) $display("FAIL reg3 got %h want a3", regs[3*W +: W]); else n_pass++;
    tick();
    drive(1'b0, 5'd0, '0, 1'b0);
    n_checks++; if (commit_en !== 32'h800) $display("FAIL held_c11 got %h want 00000800", commit_en); else n_pass++;
    n_checks++; if (pending !== 32'h800) $display("FAIL held_pending got %h want 00000800", pending); else n_pass++;
    tick();
    n_checks++; if (regs[11*W +: W] !== 64'hCB) $display("FAIL reg11 got %h want cb", regs[11*W +: W]); else n_pass++;
    n_checks++; if (regs[7*W +: W] !== 64'hB7) $display("FAIL reg7 got %h want b7", regs[7*W +: W]); else n_pass++;
  endtask

  task automatic test_xzr();
    drive(1'b1, 5'd31, 64'hFFFF, 1'b0);
    n_checks++; if (wif.wr_ready !== 1'b1) $display("FAIL xzr_ready got %b want 1", wif.wr_ready); else n_pass++;
    tick();
    drive(1'b0, 5'd0, '0, 1'b0);
    n_checks++; if (commit_en !== 32'd0) $display("FAIL xzr_commit got %h want 0", commit_en); else n_pass++;
    n_checks++; if (pending !== 32'd0) $display("FAIL xzr_pending got %h want 0", pending); else n_pass++;
    tick();
    n_checks++; if (regs[31*W +: W] !== '0) $display("FAIL xzr_reg got %h want 0", regs[31*W +: W]); else n_pass++;
    n_checks++; if (wif.wr_ready !== 1'b1) $display("FAIL xzr_drained got %b want 1", wif.wr_ready); else n_pass++;
  endtask

  task automatic test_same_reg();
    drive(1'b1, 5'd9, 64'd1, 1'b1); tick();
    drive(1'b1, 5'd9, 64'd2, 1'b1); tick();
    drive(1'b0, 5'd0, '0, 1'b0);
    n_checks++; if (pending !== 32'h200) $display("FAIL same_pending got %h want 00000200", pending); else n_pass++;
    tick();
    n_checks++; if (regs[9*W +: W] !== 64'd1) $display("FAIL same_first got %h want 1", regs[9*W +: W]); else n_pass++;
    n_checks++; if (pending !== 32'h200) $display("FAIL same_pending2 got %h want 00000200", pending); else n_pass++;
    tick();
    n_checks++; if (regs[9*W +: W] !== 64'd2) $display("FAIL same_last got %h want 2", regs[9*W +: W]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int bad;
    for (int i = 0; i < 3*DEPTH + 2; i++) begin
      drive(1'b1, 5'($urandom_range(0, 30)), {$urandom, $urandom}, 1'b0);
      n_checks++; if (wif.wr_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got %b want 1", i, wif.wr_ready); else n_pass++;
      n_checks++; if (commit_en !== exp_commit()) $display("FAIL b2b_commit[%0d] got %h want %h", i, commit_en, exp_commit()); else n_pass++;
      tick();
    end
    drive(1'b0, 5'd0, '0, 1'b0);
    tick();
    bad = first_bad_reg();
    n_checks++; if (bad >= 0) $display("FAIL b2b_regs reg %0d got %h want %h", bad, regs[bad*W +: W], mregs[bad]); else n_pass++;
  endtask

  task automatic test_random();
    int bad;
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom), {$urandom, $urandom}, ($urandom_range(0, 3) == 0));
      n_checks++; if (wif.wr_ready !== exp_ready()) $display("FAIL rnd_ready[%0d] got %b want %b", i, wif.wr_ready, exp_ready()); else n_pass++;
      n_checks++; if (commit_en !== exp_commit()) $display("FAIL rnd_commit[%0d] got %h want %h", i, commit_en, exp_commit()); else n_pass++;
      n_checks++; if (pending !== exp_pending()) $display("FAIL rnd_pending[%0d] got %h want %h", i, pending, exp_pending()); else n_pass++;
      bad = first_bad_reg();
      n_checks++; if (bad >= 0) $display("FAIL rnd_regs[%0d] reg %0d got %h want %h", i, bad, regs[bad*W +: W], mregs[bad]); else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_full();
    int bad;
    drive(1'b1, 5'd1, 64'h11, 1'b0); tick();
    drive(1'b1, 5'd2, 64'h22, 1'b1); tick();
    drive(1'b1, 5'd4, 64'h44, 1'b1); tick();
    n_checks++; if (wif.wr_ready !== 1'b0) $display("FAIL rf_full got %b want 0", wif.wr_ready); else n_pass++;
    drive(1'b1, 5'd6, 64'h66, 1'b0, 1'b1);
    tick();
    drive(1'b0, 5'd0, '0, 1'b0);
    n_checks++; if (wif.wr_ready !== 1'b1) $display("FAIL rf_ready got %b want 1", wif.wr_ready); else n_pass++;
    n_checks++; if (pending !== 32'd0) $display("FAIL rf_pending got %h want 0", pending); else n_pass++;
    n_checks++; if (commit_en !== 32'd0) $display("FAIL rf_commit got %h want 0", commit_en); else n_pass++;
    tick(); tick();
    bad = -1;
    for (int r = 0; r < 32; r++) if (bad < 0 && regs[r*W +: W] !== '0) bad = r;
    n_checks++; if (bad >= 0) $display("FAIL rf_regs reg %0d got %h want 0", bad, regs[bad*W +: W]); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; drain_stall = 1'b0;
    wif.wr_valid = 1'b0; wif.wr_addr = '0; wif.wr_data = '0;
    for (int r = 0; r < 32; r++) mregs[r] = '0;
    test_reset();
    test_single();
    test_stall();
    test_xzr();
    test_same_reg();
    test_back_to_back();
    test_random();
    test_reset_full();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
